router_sync_n: RTL and testbench
================================

# router_sync_n

Parametrised write-steering and FIFO-watchdog block for the router, sitting between the router FSM and NUM_CH output FIFOs. It latches the destination address on `detect_add` and steers the FSM's write strobe to one FIFO as a one-hot enable. It reflects that FIFO's full flag back to the FSM and drives per-channel valid outputs. Per channel, it raises a one-cycle `soft_reset` pulse when data sits unread for TIMEOUT cycles, and it flags out-of-range addresses instead of silently defaulting.

## Interface
- NUM_CH, 3, number of output channels/FIFOs (2..8)
- ADDR_W, 2, width of address field in `data_in`; must satisfy 2**ADDR_W >= NUM_CH
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (>= 2)
- CNT_W, $clog2(TIMEOUT), derived; not to be overridden
- clock  in  1  single clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- detect_add  in  1  FSM strobe: `data_in` carries the header address this cycle
- data_in  in  ADDR_W  destination address
- write_enb_reg  in  1  FSM write strobe for the current packet byte
- full  in  NUM_CH  per-FIFO full flags
- empty  in  NUM_CH  per-FIFO empty flags
- read_enb  in  NUM_CH  per-FIFO read enables from the output side
- write_enb  out  NUM_CH  one-hot (or zero) FIFO write enable
- fifo_full  out  1  full flag of the currently addressed FIFO
- vld_out  out  NUM_CH  per-channel data valid = ~empty
- soft_reset  out  NUM_CH  registered one-cycle watchdog pulse per FIFO
- addr_err  out  1  registered: latched address is >= NUM_CH

## Operation
- Address register `addr_q` (ADDR_W) resets to 0. On `detect_add`=1 it loads `data_in`, and `addr_err` loads (`data_in` >= NUM_CH). Both otherwise hold.
- Steering is combinational on `addr_q`, `addr_err`, `write_enb_reg`, `full`:
  - `addr_err`=0: `write_enb` = `write_enb_reg` ? (1 << `addr_q`) : 0, and `fifo_full` = `full[addr_q]`.
  - `addr_err`=1: `write_enb` = 0 and `fifo_full` = 0, so the packet is dropped without stalling the FSM.
- `vld_out[i]` = ~`empty[i]`, combinational.
- Watchdog, per channel i, with counter `cnt[i]` (CNT_W bits) resetting to 0:
  - `empty[i]`=1 or `read_enb[i]`=1: `cnt` <= 0, `soft_reset[i]` <= 0.
  - Otherwise, if `cnt` == TIMEOUT-1: `soft_reset[i]` <= 1 and `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt`+1 and `soft_reset[i]` <= 0.
- Channels are fully independent; any number of channels may pulse in the same cycle.

## Timing
- Reset values: `addr_q`=0, `addr_err`=0, all `cnt`=0, `soft_reset`=0. While in reset, `write_enb` follows `write_enb_reg` to channel 0, `fifo_full`=`full[0]`, and `vld_out`=~`empty`.
- Address latency is 1 cycle. If `detect_add` and `write_enb_reg` are asserted in the same cycle, steering uses the old `addr_q`; the new address steers from the next cycle.
- `soft_reset[i]` rises after the TIMEOUT-th consecutive rising edge with `vld_out[i]`=1 and `read_enb[i]`=0. It is high for exactly one cycle.
- If the channel stays stuck, pulses repeat every TIMEOUT cycles.
- A single cycle with `read_enb[i]`=1 or `empty[i]`=1 restarts the count. Such a cycle coinciding with `cnt`==TIMEOUT-1 suppresses the pulse.
- The counter never wraps past TIMEOUT-1.
- `resetn`=0 mid-count clears the counter and any pending/high `soft_reset` at that edge.
- `full` changing while addressed propagates to `fifo_full` in the same cycle.

## Structure
- Shared package `router_pkg`: default constants ROUTER_NUM_CH=3, ROUTER_ADDR_W=2, ROUTER_TIMEOUT=30.
- One sub-module `router_sync_wdog` (per-channel counter plus pulse, parameter TIMEOUT). Instantiate it NUM_CH times in a generate loop.
- Address latch and steering decode stay in the top level.

## Test plan
- Reset, then `detect_add`=1 with `data_in`=2 and `write_enb_reg`=1 next cycle -> `write_enb`=3'b100. With `full`=3'b100 -> `fifo_full`=1.
- Same-cycle `detect_add` (`data_in`=1) with `write_enb_reg` while `addr_q`=0 -> `write_enb`=3'b001 that cycle, then 3'b010 the following cycle.
- NUM_CH=3, `data_in`=3 latched -> `addr_err`=1, `write_enb`=0, `fifo_full`=0 even with `full`=3'b111. A valid `detect_add` with `data_in`=0 clears `addr_err`.
- `empty[0]`=0 with `read_enb[0]`=0 held for 65 cycles, TIMEOUT=30 -> `soft_reset[0]` high exactly after edges 30 and 60, one cycle each; channels 1 and 2 stay 0.
- Stuck channel with `read_enb[1]`=1 pulsed on edge 29 -> no pulse at 30. The next pulse comes 30 edges after the read.
- `resetn`=0 asserted at `cnt`=29 -> `soft_reset` stays 0 and the count restarts from 0 after release. Rerun the watchdog scenario with NUM_CH=4 and TIMEOUT=5 to check parametrisation.

Source files
------------

// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router write-steering / watchdog block.
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_ADDR_W  = 2;
  localparam int ROUTER_TIMEOUT = 30;

  function automatic logic addr_out_of_range(input int unsigned addr, input int unsigned num_ch);
    return addr >= num_ch;
  endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// Per-channel watchdog: emits a one-cycle soft reset after TIMEOUT
// consecutive cycles of unread valid data in the attached FIFO.
module router_sync_wdog import router_pkg::*; #(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clock_i,
  input  logic resetn_i,
  input  logic empty_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;

  // Any read or an empty FIFO restarts the count and also cancels a pulse due this cycle.
  always_comb begin
    soft_reset_d = 1'b0;
    cnt_d        = cnt_q + CNT_W'(1);
    if (empty_i || read_enb_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
      cnt_d        = '0;
      soft_reset_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset_o = soft_reset_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the destination address, steers the FSM write
// strobe to one FIFO, reflects its full flag and runs a watchdog per FIFO.
module router_sync_n import router_pkg::*; #(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int ADDR_W  = ROUTER_ADDR_W,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              detect_add_i,
  input  logic [ADDR_W-1:0] data_in_i,
  input  logic              write_enb_reg_i,
  input  logic [NUM_CH-1:0] full_i,
  input  logic [NUM_CH-1:0] empty_i,
  input  logic [NUM_CH-1:0] read_enb_i,
  output logic [NUM_CH-1:0] write_enb_o,
  output logic              fifo_full_o,
  output logic [NUM_CH-1:0] vld_out_o,
  output logic [NUM_CH-1:0] soft_reset_o,
  output logic              addr_err_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_err_q, addr_err_d;

  always_comb begin
    addr_d     = addr_q;
    addr_err_d = addr_err_q;
    if (detect_add_i) begin
      addr_d     = data_in_i;
      addr_err_d = addr_out_of_range(32'(data_in_i), NUM_CH);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  // A bad address drops the packet: no write strobe and no back-pressure to the FSM.
  always_comb begin
    write_enb_o = '0;
    fifo_full_o = 1'b0;
    if (!addr_err_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr_q == ADDR_W'(i)) begin
          write_enb_o[i] = write_enb_reg_i;
          fifo_full_o    = full_i[i];
        end
      end
    end
  end

  assign vld_out_o  = ~empty_i;
  assign addr_err_o = addr_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
    router_sync_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clock_i     (clock_i),
      .resetn_i    (resetn_i),
      .empty_i     (empty_i[g]),
      .read_enb_i  (read_enb_i[g]),
      .soft_reset_o(soft_reset_o[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: default build (3 ch, TIMEOUT 30) and a 4 ch, TIMEOUT 5 build
// checked every cycle against a run-length model plus directed literal checks.
module tb_router_sync_n;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detAdd [2];
  logic [1:0] dataIn [2];
  logic       wer    [2];
  logic [7:0] full   [2];
  logic [7:0] empty  [2];
  logic [7:0] rd     [2];

  logic [2:0] weA, vldA, softA;
  logic [3:0] weB, vldB, softB;
  logic       ffAct  [2];
  logic       errAct [2];

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  int mAddr  [2];
  bit mErr   [2];
  int runLen [2][8];
  bit mSoft  [2][8];

  always #5 clock = ~clock;

  router_sync_n dutA (
    .clock_i(clock), .resetn_i(resetn), .detect_add_i(detAdd[0]), .data_in_i(dataIn[0]),
    .write_enb_reg_i(wer[0]), .full_i(full[0][2:0]), .empty_i(empty[0][2:0]),
    .read_enb_i(rd[0][2:0]), .write_enb_o(weA), .fifo_full_o(ffAct[0]),
    .vld_out_o(vldA), .soft_reset_o(softA), .addr_err_o(errAct[0])
  );

  router_sync_n #(.NUM_CH(4), .ADDR_W(2), .TIMEOUT(5)) dutB (
    .clock_i(clock), .resetn_i(resetn), .detect_add_i(detAdd[1]), .data_in_i(dataIn[1]),
    .write_enb_reg_i(wer[1]), .full_i(full[1][3:0]), .empty_i(empty[1][3:0]),
    .read_enb_i(rd[1][3:0]), .write_enb_o(weB), .fifo_full_o(ffAct[1]),
    .vld_out_o(vldB), .soft_reset_o(softB), .addr_err_o(errAct[1])
  );

  function automatic int numCh(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic int timeoutOf(input int k);
    return (k == 0) ? 30 : 5;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A pulse is due whenever the current stuck run length reaches a multiple of TIMEOUT.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        mAddr[k] = 0;
        mErr[k]  = 1'b0;
        for (int c = 0; c < 8; c++) begin
          runLen[k][c] = 0;
          mSoft[k][c]  = 1'b0;
        end
      end else begin
        if (detAdd[k]) begin
          mAddr[k] = int'(dataIn[k]);
          mErr[k]  = (mAddr[k] >= numCh(k));
        end
        for (int c = 0; c < numCh(k); c++) begin
          if (!empty[k][c] && !rd[k][c]) begin
            runLen[k][c] = runLen[k][c] + 1;
            mSoft[k][c]  = (runLen[k][c] % timeoutOf(k)) == 0;
          end else begin
            runLen[k][c] = 0;
            mSoft[k][c]  = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        int mask, expWe, expFf, expSoft, actWe, actVld, actSoft;
        mask    = (1 << numCh(k)) - 1;
        expWe   = (!mErr[k] && wer[k]) ? (1 << mAddr[k]) : 0;
        expFf   = mErr[k] ? 0 : int'(full[k][mAddr[k]]);
        expSoft = 0;
        for (int c = 0; c < numCh(k); c++) expSoft |= int'(mSoft[k][c]) << c;
        actWe   = (k == 0) ? int'(weA)   : int'(weB);
        actVld  = (k == 0) ? int'(vldA)  : int'(vldB);
        actSoft = (k == 0) ? int'(softA) : int'(softB);
        checkOutput($sformatf("model_we%0d", k),   actWe,            expWe);
        checkOutput($sformatf("model_ff%0d", k),   int'(ffAct[k]),   expFf);
        checkOutput($sformatf("model_vld%0d", k),  actVld,           int'(~empty[k]) & mask);
        checkOutput($sformatf("model_soft%0d", k), actSoft,          expSoft);
        checkOutput($sformatf("model_err%0d", k),  int'(errAct[k]),  int'(mErr[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic da, input logic [1:0] d, input logic w);
    for (int k = 0; k < 2; k++) begin
      detAdd[k] = da;
      dataIn[k] = d;
      wer[k]    = w;
    end
  endtask

  initial begin
    int pulsesA[$];
    int pulsesB[$];
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      full[k] = '0; empty[k] = 8'hFF; rd[k] = '0;
    end
    applyStimulus(1'b0, 2'd0, 1'b1);
    full[0] = 8'h01;
    tick();
    tick();
    @(negedge clock);
    checkOutput("rst_we", int'(weA), 1);
    checkOutput("rst_ff", int'(ffAct[0]), 1);
    checkOutput("rst_soft", int'(softA), 0);
    checkOutput("rst_err", int'(errAct[0]), 0);

    resetn = 1'b1;
    checking = 1'b1;
    applyStimulus(1'b1, 2'd2, 1'b0);
    full[0] = '0;
    tick();
    applyStimulus(1'b0, 2'd2, 1'b1);
    full[0] = 8'h04;
    @(negedge clock);
    checkOutput("addr2_we", int'(weA), 3'b100);
    checkOutput("addr2_ff", int'(ffAct[0]), 1);

    applyStimulus(1'b1, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, 1'b1);
    @(negedge clock);
    checkOutput("same_cycle_old", int'(weA), 3'b001);
    tick();
    applyStimulus(1'b0, 2'd1, 1'b1);
    @(negedge clock);
    checkOutput("same_cycle_new", int'(weA), 3'b010);

    applyStimulus(1'b1, 2'd3, 1'b1);
    full[0] = 8'h07;
    full[1] = 8'h0F;
    tick();
    applyStimulus(1'b0, 2'd3, 1'b1);
    @(negedge clock);
    checkOutput("err_flag", int'(errAct[0]), 1);
    checkOutput("err_we", int'(weA), 0);
    checkOutput("err_ff", int'(ffAct[0]), 0);
    checkOutput("b_addr3_we", int'(weB), 4'b1000);
    checkOutput("b_addr3_err", int'(errAct[1]), 0);
    applyStimulus(1'b1, 2'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(negedge clock);
    checkOutput("err_clear", int'(errAct[0]), 0);
    checkOutput("err_clear_we", int'(weA), 3'b001);
    checkOutput("err_clear_ff", int'(ffAct[0]), 1);
    applyStimulus(1'b0, 2'd0, 1'b0);
    full[0] = '0;
    full[1] = '0;

    // Stuck channel 0 on A and channel 1 on B for 65 edges.
    empty[0] = 8'hFE;
    empty[1] = 8'hFD;
    for (int n = 1; n <= 65; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (softA[0]) pulsesA.push_back(n);
      if (softB[1]) pulsesB.push_back(n);
    end
    checkOutput("wdA_count", pulsesA.size(), 2);
    if (pulsesA.size() == 2) begin
      checkOutput("wdA_first", pulsesA[0], 30);
      checkOutput("wdA_second", pulsesA[1], 60);
    end
    checkOutput("wdB_count", pulsesB.size(), 13);
    if (pulsesB.size() > 0) checkOutput("wdB_first", pulsesB[0], 5);
    empty[0] = 8'hFF;
    empty[1] = 8'hFF;
    tick();

    pulsesA.delete();
    empty[0] = 8'hFD;
    for (int n = 1; n <= 70; n++) begin
      rd[0][1] = (n == 29);
      @(posedge clock);
      @(negedge clock);
      if (softA[1]) pulsesA.push_back(n);
    end
    rd[0] = '0;
    checkOutput("rd_count", pulsesA.size(), 1);
    if (pulsesA.size() == 1) checkOutput("rd_pulse_edge", pulsesA[0], 59);
    empty[0] = 8'hFF;
    tick();

    pulsesA.delete();
    empty[0] = 8'hFE;
    for (int n = 1; n <= 65; n++) begin
      resetn = (n != 30);
      @(posedge clock);
      @(negedge clock);
      if (softA[0]) pulsesA.push_back(n);
    end
    resetn = 1'b1;
    checkOutput("rst_mid_count", pulsesA.size(), 1);
    if (pulsesA.size() == 1) checkOutput("rst_mid_edge", pulsesA[0], 60);
    empty[0] = 8'hFF;
    tick();
    tick();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
